// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants, coordinate width,
// region boundary helpers and the registered raster bundle type.
// Shared by vga_sync_module, vga_control_module and their testbenches.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int sync_start(int visible, int front);
        return visible + front;
    endfunction

    function automatic int sync_end(int visible, int front, int sync);
        return visible + front + sync;
    endfunction

    function automatic int axis_total(int visible, int front, int sync,
                                      int back);
        return visible + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT,
                                            DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT,
                                            DEF_V_SYNC, DEF_V_BACK);

    localparam int DEF_H_SYNC_START = sync_start(DEF_H_VISIBLE, DEF_H_FRONT);
    localparam int DEF_H_SYNC_END   = sync_end(DEF_H_VISIBLE, DEF_H_FRONT,
                                               DEF_H_SYNC);
    localparam int DEF_V_SYNC_START = sync_start(DEF_V_VISIBLE, DEF_V_FRONT);
    localparam int DEF_V_SYNC_END   = sync_end(DEF_V_VISIBLE, DEF_V_FRONT,
                                               DEF_V_SYNC);

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   valid;
        logic   hsync;
        logic   vsync;
        logic   frame_start;
    } raster_t;

    localparam raster_t RASTER_RESET = '{
        x:           '0,
        y:           '0,
        valid:       1'b0,
        hsync:       1'b1,
        vsync:       1'b1,
        frame_start: 1'b0
    };

endpackage

// File: rtl/vga_sync_module_if.sv
// vga_sync_module_if: raster bundle from the sync generator to its consumer.
// master drives X, Y, valid, VGA_HSYNC, VGA_VSYNC, FRAME_START; slave reads.
interface vga_sync_module_if;
    import vga_timing_pkg::*;

    coord_t X;
    coord_t Y;
    logic   valid;
    logic   VGA_HSYNC;
    logic   VGA_VSYNC;
    logic   FRAME_START;

    modport master (
        output X, Y, valid, VGA_HSYNC, VGA_VSYNC, FRAME_START
    );

    modport slave (
        input X, Y, valid, VGA_HSYNC, VGA_VSYNC, FRAME_START
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter, 0..TOTAL-1 with wrap.
// Ports: VGA_CLK, RST (sync, active-high), inc in; cnt, wrap, in_visible,
// in_sync out (region flags decode the current cnt).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int VISIBLE    = DEF_H_VISIBLE,
    parameter int SYNC_START = DEF_H_SYNC_START,
    parameter int SYNC_END   = DEF_H_SYNC_END
) (
    input  logic   VGA_CLK,
    input  logic   RST,
    input  logic   inc,
    output coord_t cnt,
    output logic   wrap,
    output logic   in_visible,
    output logic   in_sync
);

    localparam int CW = COORD_W + 1;

    if (TOTAL < 2 || TOTAL > MAX_TOTAL) begin : g_bad_total
        $fatal(1, "vga_axis_counter: TOTAL %0d out of range", TOTAL);
    end

    if (VISIBLE > SYNC_START || SYNC_START > SYNC_END || SYNC_END > TOTAL)
    begin : g_bad_regions
        $fatal(1, "vga_axis_counter: inconsistent region boundaries");
    end

    localparam coord_t         LAST   = COORD_W'(TOTAL - 1);
    localparam logic [CW-1:0]  VIS_W  = CW'(VISIBLE);
    localparam logic [CW-1:0]  SS_W   = CW'(SYNC_START);
    localparam logic [CW-1:0]  SE_W   = CW'(SYNC_END);

    // One spare bit so boundaries equal to 1024 compare correctly.
    logic [CW-1:0] cnt_w;

    assign cnt_w      = {1'b0, cnt};
    assign wrap       = (cnt == LAST);
    assign in_visible = (cnt_w < VIS_W);
    assign in_sync    = (cnt_w >= SS_W) && (cnt_w < SE_W);

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_module.sv
// vga_sync_module: 640x480@60 raster timing generator with clock enable.
// Ports: VGA_CLK, RST (sync, active-high), CE in; vga (master) carries
// X, Y, valid, VGA_HSYNC, VGA_VSYNC, FRAME_START, all registered.
// Macro VGA_SYNC_PIPE_EN: delay HSYNC/VSYNC by one more CE-gated stage.
module vga_sync_module
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic              VGA_CLK,
    input  logic              RST,
    input  logic              CE,
    vga_sync_module_if.master vga
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    coord_t  h_cnt;
    coord_t  v_cnt;
    logic    h_wrap;
    logic    v_wrap;
    logic    h_vis;
    logic    v_vis;
    logic    h_sync;
    logic    v_sync;
    logic    v_inc;
    logic    at_origin;
    raster_t dec;
    raster_t out_q;

    assign v_inc = CE && h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (sync_start(H_VISIBLE, H_FRONT)),
        .SYNC_END   (sync_end(H_VISIBLE, H_FRONT, H_SYNC))
    ) u_h_cnt (
        .VGA_CLK    (VGA_CLK),
        .RST        (RST),
        .inc        (CE),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .in_visible (h_vis),
        .in_sync    (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (sync_start(V_VISIBLE, V_FRONT)),
        .SYNC_END   (sync_end(V_VISIBLE, V_FRONT, V_SYNC))
    ) u_v_cnt (
        .VGA_CLK    (VGA_CLK),
        .RST        (RST),
        .inc        (v_inc),
        .cnt        (v_cnt),
        .wrap       (v_wrap),
        .in_visible (v_vis),
        .in_sync    (v_sync)
    );

    // Tracks (h_cnt, v_cnt) == (0, 0): the pair only returns to the
    // origin when both axes wrap on the same enabled edge.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            at_origin <= 1'b1;
        end else if (CE) begin
            at_origin <= h_wrap && v_wrap;
        end
    end

    always_comb begin
        dec             = RASTER_RESET;
        dec.valid       = h_vis && v_vis;
        dec.x           = dec.valid ? h_cnt : '0;
        dec.y           = dec.valid ? v_cnt : '0;
        dec.hsync       = !h_sync;
        dec.vsync       = !v_sync;
        dec.frame_start = at_origin;
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            out_q <= RASTER_RESET;
        end else if (CE) begin
            out_q <= dec;
        end
    end

    assign vga.X           = out_q.x;
    assign vga.Y           = out_q.y;
    assign vga.valid       = out_q.valid;
    assign vga.FRAME_START = out_q.frame_start;

`ifdef VGA_SYNC_PIPE_EN
    // Extra sync stage lines the pins up with the registered RGB path.
    logic hs_q;
    logic vs_q;

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (CE) begin
            hs_q <= out_q.hsync;
            vs_q <= out_q.vsync;
        end
    end

    assign vga.VGA_HSYNC = hs_q;
    assign vga.VGA_VSYNC = vs_q;
`else
    assign vga.VGA_HSYNC = out_q.hsync;
    assign vga.VGA_VSYNC = out_q.vsync;
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// tb_vga_sync_module: scoreboard bench for vga_sync_module, one default
// 640x480 instance and one small-raster instance sharing RST/CE.
module tb_vga_sync_module;
    import vga_timing_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   valid;
        logic   hs;
        logic   vs;
        logic   fs;
    } obs_t;

`ifdef VGA_SYNC_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, valid: 1'b0,
                                 hs: 1'b1, vs: 1'b1, fs: 1'b0};
    localparam obs_t ORG_OBS = '{x: 10'd0, y: 10'd0, valid: 1'b1,
                                 hs: 1'b1, vs: 1'b1, fs: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    vga_sync_module_if bus_a ();
    vga_sync_module_if bus_b ();

    vga_sync_module dut_a (
        .VGA_CLK (clk),
        .RST     (rst),
        .CE      (ce),
        .vga     (bus_a)
    );

    vga_sync_module #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut_b (
        .VGA_CLK (clk),
        .RST     (rst),
        .CE      (ce),
        .vga     (bus_b)
    );

    int p_hv [2] = '{640, 8};
    int p_hf [2] = '{16, 2};
    int p_hs [2] = '{96, 3};
    int p_hb [2] = '{48, 2};
    int p_vv [2] = '{480, 4};
    int p_vf [2] = '{10, 1};
    int p_vs [2] = '{2, 2};
    int p_vb [2] = '{33, 1};

    int   mh  [2];
    int   mv  [2];
    obs_t mo  [2];
    logic mph [2];
    logic mpv [2];
    obs_t sb  [$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int phase  = 0;
    int ea     = 0;

    obs_t prv [2];
    obs_t a_first;
    int   a_x639   = -1;
    int   a_vfall  = -1;
    int   a_hsrise = -1;
    int   a_hsfall [$];
    int   b_rise   [$];
    int   b_fs_run = 0;
    int   b_fs_len = -1;
    int   b_vs_run = 0;
    int   b_vs_len = -1;
    int   b_ybad   = 0;

    function automatic obs_t dec(int i, int h, int v);
        obs_t o;
        logic vis;
        int   ss;
        vis     = (h < p_hv[i]) && (v < p_vv[i]);
        o.valid = vis;
        o.x     = vis ? 10'(h) : 10'd0;
        o.y     = vis ? 10'(v) : 10'd0;
        ss      = p_hv[i] + p_hf[i];
        o.hs    = !(h >= ss && h < ss + p_hs[i]);
        ss      = p_vv[i] + p_vf[i];
        o.vs    = !(v >= ss && v < ss + p_vs[i]);
        o.fs    = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic void model_edge(int i, logic r, logic c);
        obs_t e;
        int   ht;
        int   vt;
        ht = p_hv[i] + p_hf[i] + p_hs[i] + p_hb[i];
        vt = p_vv[i] + p_vf[i] + p_vs[i] + p_vb[i];
        if (r) begin
            mh[i]  = 0;
            mv[i]  = 0;
            mo[i]  = RST_OBS;
            mph[i] = 1'b1;
            mpv[i] = 1'b1;
        end else if (c) begin
            mph[i] = mo[i].hs;
            mpv[i] = mo[i].vs;
            mo[i]  = dec(i, mh[i], mv[i]);
            if (mh[i] == ht - 1) begin
                mh[i] = 0;
                mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
            end else begin
                mh[i] = mh[i] + 1;
            end
        end
        e = mo[i];
        if (PIPE == 1) begin
            e.hs = mph[i];
            e.vs = mpv[i];
        end
        sb.push_back(e);
    endfunction

    function automatic obs_t get(int i);
        obs_t o;
        if (i == 0) begin
            o = '{x: bus_a.X, y: bus_a.Y, valid: bus_a.valid,
                  hs: bus_a.VGA_HSYNC, vs: bus_a.VGA_VSYNC,
                  fs: bus_a.FRAME_START};
        end else begin
            o = '{x: bus_b.X, y: bus_b.Y, valid: bus_b.valid,
                  hs: bus_b.VGA_HSYNC, vs: bus_b.VGA_VSYNC,
                  fs: bus_b.FRAME_START};
        end
        return o;
    endfunction

    function automatic void mon(int i, obs_t o);
        if (i == 0) begin
            if (phase == 1) begin
                if (ea == 1) a_first = o;
                if (o.valid && o.x == 10'd639 && a_x639 < 0) a_x639 = ea;
                if (prv[0].valid && !o.valid && a_vfall < 0) a_vfall = ea;
                if (prv[0].hs && !o.hs) a_hsfall.push_back(ea);
                if (!prv[0].hs && o.hs && a_hsrise < 0) a_hsrise = ea;
            end
        end else begin
            if (o.fs && !prv[1].fs) b_rise.push_back(cyc);
            if (o.fs) begin
                b_fs_run++;
            end else begin
                if (b_fs_run > 0) b_fs_len = b_fs_run;
                b_fs_run = 0;
            end
            if (!o.vs) begin
                b_vs_run++;
            end else begin
                if (b_vs_run > 0 && b_vs_len < 0) b_vs_len = b_vs_run;
                b_vs_run = 0;
            end
            if (o.valid && o.y > 10'd3) b_ybad++;
        end
        prv[i] = o;
    endfunction

    task automatic chk(input string tag, input int o, input int e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t o, input obs_t e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input logic r, input logic c);
        obs_t e;
        obs_t o;
        rst = r;
        ce  = c;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, r, c);
        #1;
        cyc++;
        if (phase == 1) ea++;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            o = get(i);
            n_chk++;
            assert (o === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL sb%0d cyc=%0d observed=%h expected=%h",
                       i, cyc, o, e);
            end
            mon(i, o);
        end
    endtask

    initial begin
        bit found;

        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        chk_obs("reset_a", get(0), RST_OBS);
        chk_obs("reset_b", get(1), RST_OBS);

        phase = 1;
        repeat (1700) step(1'b0, 1'b1);
        chk_obs("first_edge_a", a_first, ORG_OBS);
        chk("x639_edge", a_x639, 640);
        chk("valid_fall_edge", a_vfall, 641);
        chk("hs_fall_count", a_hsfall.size(), 2);
        if (a_hsfall.size() >= 2) begin
            chk("hs_fall_edge", a_hsfall[0], 657 + PIPE);
            chk("hs_period", a_hsfall[1] - a_hsfall[0], 800);
            chk("hs_low_len", a_hsrise - a_hsfall[0], 96);
        end
        chk("b_fs_count", b_rise.size(), 15);
        if (b_rise.size() >= 2) begin
            chk("b_frame_period", b_rise[1] - b_rise[0], 120);
            chk("b_frame_period_last",
                b_rise[b_rise.size()-1] - b_rise[b_rise.size()-2], 120);
        end
        chk("b_fs_len", b_fs_len, 1);
        chk("b_vs_len", b_vs_len, 30);
        chk("b_y_in_visible", b_ybad, 0);

        phase = 2;
        b_rise.delete();
        b_fs_len = -1;
        for (int k = 0; k < 600; k++) step(1'b0, (k % 2) == 0);
        chk("b_ce_fs_count", b_rise.size(), 2);
        if (b_rise.size() >= 2) begin
            chk("b_ce_frame_period", b_rise[1] - b_rise[0], 240);
        end
        chk("b_ce_fs_len", b_fs_len, 2);

        phase = 3;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step(1'b0, 1'b1);
            if (prv[1].valid && prv[1].x == 10'd5 && prv[1].y == 10'd2)
                found = 1'b1;
        end
        chk("b_reach_mid", int'(found), 1);
        step(1'b1, 1'b0);
        chk_obs("mid_reset_a", get(0), RST_OBS);
        chk_obs("mid_reset_b", get(1), RST_OBS);
        step(1'b0, 1'b0);
        chk_obs("hold_after_rst_b", get(1), RST_OBS);
        step(1'b0, 1'b1);
        chk_obs("restart_a", get(0), ORG_OBS);
        chk_obs("restart_b", get(1), ORG_OBS);
        repeat (20) step(1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
